// File: rtl/mux8_serial_ctrl.sv
// rtl/mux8_serial_ctrl.sv - flow-controlled parallel-to-serial sequencer around an external 8:1 mux
//
// Purpose:
//   Accepts an 8-bit word over a valid/ready load handshake. The block holds the word on the
//   mux data inputs and steps the mux select one beat at a time. The selected bit (mux Y) is
//   returned as a serial stream with valid/ready/last.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   load_valid  upstream offers load_data
//   load_ready  block can accept a word (IDLE only)
//   load_data   word to serialize
//   mux_i       registered word, drives mux I
//   mux_s       registered select, drives mux S
//   mux_y       mux output Y
//   ser_valid   ser_bit is valid
//   ser_ready   downstream accepts ser_bit
//   ser_bit     serial bit (mux_y gated by ser_valid)
//   ser_last    high with the 8th bit of a word
//   busy        a word is being shifted
//
// Parameter MSB_FIRST: 0 = bit 0 first (select 0..7), 1 = bit 7 first (select 7..0).

module mux8_serial_ctrl #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [7:0] load_data,
    output logic [7:0] mux_i,
    output logic [2:0] mux_s,
    input  logic       mux_y,
    output logic       ser_valid,
    input  logic       ser_ready,
    output logic       ser_bit,
    output logic       ser_last,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [2:0] SEL_START = MSB_FIRST ? 3'd7 : 3'd0;

    state_t     state_q, state_d;
    logic [7:0] word_q, word_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] count_q, count_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= 8'h00;
            sel_q   <= 3'd0;
            count_q <= 3'd0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            sel_q   <= sel_d;
            count_q <= count_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        sel_d   = sel_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    word_d  = load_data;
                    sel_d   = SEL_START;
                    count_d = 3'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_ready) begin
                    if (count_q == 3'd7) begin
                        // Word done: word and select keep their last values.
                        state_d = IDLE;
                    end else begin
                        // The counter bounds the select, so it never wraps within a word.
                        count_d = count_q + 3'd1;
                        sel_d   = MSB_FIRST ? (sel_q - 3'd1) : (sel_q + 3'd1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        load_ready = (state_q == IDLE);
        ser_valid  = (state_q == SHIFT);
        busy       = (state_q == SHIFT);
        // The last beat is decoded from the beat count, so it works in both bit orders.
        ser_last   = (state_q == SHIFT) && (count_q == 3'd7);
        ser_bit    = (state_q == SHIFT) && mux_y;
    end

    assign mux_i = word_q;
    assign mux_s = sel_q;

endmodule

// File: tb/tb_mux8_serial_ctrl.sv
// tb/tb_mux8_serial_ctrl.sv - self-checking bench for mux8_serial_ctrl (both bit orders in lockstep)

module tb_mux8_serial_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic       ser_ready;
    logic [7:0] load_data;

    logic       lr0, lr1, my0, my1, sv0, sv1, sb0, sb1, sl0, sl1, bz0, bz1;
    logic [7:0] mi0, mi1;
    logic [2:0] ms0, ms1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 8:1 selector behaviour for each instance
    assign my0 = mi0[ms0];
    assign my1 = mi1[ms1];

    mux8_serial_ctrl #(.MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(lr0), .load_data(load_data),
        .mux_i(mi0), .mux_s(ms0), .mux_y(my0), .ser_valid(sv0), .ser_ready(ser_ready),
        .ser_bit(sb0), .ser_last(sl0), .busy(bz0)
    );

    mux8_serial_ctrl #(.MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(lr1), .load_data(load_data),
        .mux_i(mi1), .mux_s(ms1), .mux_y(my1), .ser_valid(sv1), .ser_ready(ser_ready),
        .ser_bit(sb1), .ser_last(sl1), .busy(bz1)
    );

    typedef struct {
        logic [7:0] word;
        int         stall_at;
        int         stall_len;
        bit         hold;
        logic [7:0] next_data;
        logic [7:0] exp0;       // emission order, leftmost bit first (LSB-first instance)
        logic [7:0] exp1;       // emission order, leftmost bit first (MSB-first instance)
        int         exp_vc;
    } vec_t;

    vec_t tbl[4];

    // Reference: beat k of a word carries bit k (LSB first) or bit 7-k (MSB first).
    function automatic logic exp_bit(logic [7:0] w, bit msb, int k);
        return msb ? w[7-k] : w[k];
    endfunction

    function automatic logic [2:0] exp_sel(bit msb, int k);
        return msb ? 3'(7 - k) : 3'(k);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_beat(logic [7:0] w, int k);
        chk($sformatf("sv0[%0d]", k), 32'(sv0), 1);
        chk($sformatf("sv1[%0d]", k), 32'(sv1), 1);
        chk($sformatf("bit0[%0d]", k), 32'(sb0), 32'(exp_bit(w, 1'b0, k)));
        chk($sformatf("bit1[%0d]", k), 32'(sb1), 32'(exp_bit(w, 1'b1, k)));
        chk($sformatf("sel0[%0d]", k), 32'(ms0), 32'(exp_sel(1'b0, k)));
        chk($sformatf("sel1[%0d]", k), 32'(ms1), 32'(exp_sel(1'b1, k)));
        chk($sformatf("last0[%0d]", k), 32'(sl0), 32'(k == 7));
        chk($sformatf("last1[%0d]", k), 32'(sl1), 32'(k == 7));
        chk($sformatf("mux_i0[%0d]", k), 32'(mi0), 32'(w));
        chk($sformatf("mux_i1[%0d]", k), 32'(mi1), 32'(w));
        chk($sformatf("busy0[%0d]", k), 32'(bz0), 1);
        chk($sformatf("load_ready0[%0d]", k), 32'(lr0), 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(lr0 && lr1) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_wait", 32'(lr0 && lr1), 1);
    endtask

    task automatic check_idle(string tag);
        chk({tag, "_sv0"}, 32'(sv0), 0);
        chk({tag, "_sv1"}, 32'(sv1), 0);
        chk({tag, "_bit0"}, 32'(sb0), 0);
        chk({tag, "_last0"}, 32'(sl0), 0);
        chk({tag, "_busy0"}, 32'(bz0), 0);
        chk({tag, "_busy1"}, 32'(bz1), 0);
        chk({tag, "_lr0"}, 32'(lr0), 1);
        chk({tag, "_lr1"}, 32'(lr1), 1);
    endtask

    task automatic send_word(input logic [7:0] w, input int stall_at, input int stall_len,
                             input bit hold, input logic [7:0] nxt, input int nbeats,
                             output logic [7:0] s0, output logic [7:0] s1, output int vc);
        wait_idle();
        load_valid = 1'b1;
        load_data  = w;
        @(posedge clk); #1;
        if (hold) load_data = nxt;
        else      load_valid = 1'b0;
        vc = 0;
        s0 = 8'h00;
        s1 = 8'h00;
        for (int k = 0; k < nbeats; k++) begin
            if (k == stall_at) begin
                ser_ready = 1'b0;
                for (int j = 0; j < stall_len; j++) begin
                    check_beat(w, k);
                    vc++;
                    @(posedge clk); #1;
                end
                ser_ready = 1'b1;
            end
            check_beat(w, k);
            s0[7-k] = sb0;
            s1[7-k] = sb1;
            vc++;
            if (k < 7 || nbeats == 8) begin
                @(posedge clk); #1;
            end
        end
        if (nbeats == 8) check_idle("post_word");
    endtask

    initial begin
        logic [7:0] s0, s1, w;
        int         vc, beat, cyc;

        tbl[0] = '{8'hB1, -1, 0, 1'b0, 8'h00, 8'b10001101, 8'b10110001, 8};
        tbl[1] = '{8'h5A, 2, 3, 1'b0, 8'h00, 8'b01011010, 8'b01011010, 11};
        tbl[2] = '{8'hFF, -1, 0, 1'b1, 8'h00, 8'b11111111, 8'b11111111, 8};
        tbl[3] = '{8'h00, -1, 0, 1'b0, 8'h00, 8'b00000000, 8'b00000000, 8};

        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = 8'h00;
        ser_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        chk("reset_sel0", 32'(ms0), 0);
        chk("reset_sel1", 32'(ms1), 0);
        chk("reset_mux_i0", 32'(mi0), 0);
        rst = 1'b0;

        // Entries 2 and 3 run back-to-back with load_valid held; entry 2 also has
        // load_data changed to 00 while shifting, which must be ignored.
        for (int i = 0; i < 4; i++) begin
            send_word(tbl[i].word, tbl[i].stall_at, tbl[i].stall_len, tbl[i].hold,
                      tbl[i].next_data, 8, s0, s1, vc);
            chk($sformatf("stream0[%0d]", i), 32'(s0), 32'(tbl[i].exp0));
            chk($sformatf("stream1[%0d]", i), 32'(s1), 32'(tbl[i].exp1));
            chk($sformatf("valid_cycles[%0d]", i), 32'(vc), 32'(tbl[i].exp_vc));
        end
        load_valid = 1'b0;

        // Reset after beat 3 of A5 aborts the word.
        send_word(8'hA5, -1, 0, 1'b0, 8'h00, 3, s0, s1, vc);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("abort");
        chk("abort_sel0", 32'(ms0), 0);
        chk("abort_sel1", 32'(ms1), 0);
        chk("abort_mux_i0", 32'(mi0), 0);
        chk("abort_mux_i1", 32'(mi1), 0);
        send_word(8'h01, -1, 0, 1'b0, 8'h00, 8, s0, s1, vc);
        chk("after_abort_stream0", 32'(s0), 32'(8'b10000000));
        chk("after_abort_stream1", 32'(s1), 32'(8'b00000001));

        // Random words, random backpressure, random load noise while shifting.
        for (int n = 0; n < 30; n++) begin
            w = 8'($urandom);
            wait_idle();
            load_valid = 1'b1;
            load_data  = w;
            @(posedge clk); #1;
            beat = 0;
            cyc  = 0;
            while (beat < 8 && cyc < 300) begin
                ser_ready  = 1'($urandom_range(0, 1));
                load_valid = 1'($urandom_range(0, 1));
                load_data  = 8'($urandom);
                check_beat(w, beat);
                if (ser_ready) beat++;
                @(posedge clk); #1;
                cyc++;
            end
            load_valid = 1'b0;
            ser_ready  = 1'b1;
            chk($sformatf("rand_done[%0d]", n), 32'(beat), 8);
            check_idle("rand_end");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
